seq_detect_param: RTL and testbench

Parametrised serial pattern detector, the next generation of the team's fixed-pattern sequence-detector FSM. It samples one bit per qualified clock and flags every occurrence of a compile-time pattern of configurable length. Overlapping or non-overlapping matching is selected at run time, and an optional saturating match counter is provided. It sits between a serial bit source (shift-register generator, deserialiser or pin sampler) and control logic that consumes a single-cycle match strobe.

---
 rtl/seq_detect_param.sv | 92 +++++++++
 tb/tb_seq_detect_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector: flags every occurrence of PATTERN (MSB first) in a qualified bit stream.
// Latency: out is registered, high the cycle after the edge that samples the final pattern bit.
// Backpressure: none; in_valid=0 holds all state, and one bit per clock is accepted with no bubbles.
// Optional macro SEQ_DETECT_PARAM_COUNT_EN compiles in the saturating match counter (match_cnt, cnt_sat, clr_cnt).
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int            FW   = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  // FILLING while hist holds fewer than PAT_W valid bits, ARMED once it is full.
  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [PAT_W-1:0] hist, hist_nx, hist_d;
  logic [FW-1:0]    fill, fill_d;
  logic             hit;

  // Next history, fill level, FSM state and match decision for the current bit.
  always_comb begin
    hist_nx  = {hist[PAT_W-2:0], in_bit};
    hist_d   = hist;
    fill_d   = fill;
    state_nx = state;
    hit      = 1'b0;
    if (in_valid) begin
      hist_d = hist_nx;
      fill_d = (state == ARMED) ? FULL : fill + 1'b1;
      hit    = (fill_d == FULL) && (hist_nx == PATTERN);
      // Non-overlapping mode discards the matched bits so the next match needs PAT_W fresh bits.
      if (hit && !overlap) begin
        fill_d = '0;
      end
      state_nx = (fill_d == FULL) ? ARMED : FILLING;
    end
  end

  // Detector state and the registered match strobe; reset drops any partial match.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILLING;
      hist  <= '0;
      fill  <= '0;
      out   <= 1'b0;
    end else begin
      state <= state_nx;
      hist  <= hist_d;
      fill  <= fill_d;
      out   <= hit;
    end
  end

`ifdef SEQ_DETECT_PARAM_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating match counter; a clear in the same cycle as a hit wins and the hit is not counted.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (hit && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + 1'b1;
      if (match_cnt == CNT_MAX - 1'b1) begin
        cnt_sat <= 1'b1;
      end
    end
  end
`else
  logic unused_clr;

  assign match_cnt  = '0;
  assign cnt_sat    = 1'b0;
  assign unused_clr = clr_cnt;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two configurations share one stimulus stream.
// Expected responses come from a queue-of-bits reference model and are scored by a monitor.
// Instance A: PAT_W=4 PATTERN=1010 CNT_W=8; instance B: PAT_W=3 PATTERN=111 CNT_W=2.
module tb_seq_detect_param;

  localparam int          PW_A  = 4;
  localparam logic [31:0] PAT_A = 32'b1010;
  localparam int          CW_A  = 8;
  localparam int          PW_B  = 3;
  localparam logic [31:0] PAT_B = 32'b111;
  localparam int          CW_B  = 2;
  localparam int unsigned MAX_A = (1 << CW_A) - 1;
  localparam int unsigned MAX_B = (1 << CW_B) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_bit = 1'b0;
  logic            overlap = 1'b1;
  logic            clr_cnt = 1'b0;
  logic            out_a, sat_a, out_b, sat_b;
  logic [CW_A-1:0] cnt_a;
  logic [CW_B-1:0] cnt_b;

  seq_detect_param #(.PAT_W(PW_A), .PATTERN(4'b1010), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .overlap(overlap),
    .clr_cnt(clr_cnt), .out(out_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  seq_detect_param #(.PAT_W(PW_B), .PATTERN(3'b111), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .overlap(overlap),
    .clr_cnt(clr_cnt), .out(out_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          out;
    int unsigned cnt;
    bit          sat;
  } exp_t;

  exp_t        expa[$];
  exp_t        expb[$];
  bit          qa[$];
  bit          qb[$];
  int unsigned ca = 0;
  int unsigned cb = 0;
  int          checks = 0;
  int          errors = 0;
  int          hits_a = 0;
  int          hits_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Window of the most recent bits (oldest first) matches the pattern read MSB first.
  function automatic bit window_matches(input bit q[$], input int pw, input logic [31:0] pat);
    if (q.size() != pw) return 1'b0;
    for (int i = 0; i < pw; i++) begin
      if (q[i] != pat[pw-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic exp_t make_exp(input bit hit, input int unsigned c, input int unsigned mx);
    exp_t e;
    e.out = hit;
`ifdef SEQ_DETECT_PARAM_COUNT_EN
    e.cnt = (c > mx) ? mx : c;
    e.sat = (c >= mx);
`else
    e.cnt = 0;
    e.sat = 1'b0;
`endif
    return e;
  endfunction

  // Apply one cycle of stimulus and push the response both models predict for the next edge.
  task automatic drive(input bit r, input bit v, input bit b, input bit ov, input bit clr);
    bit ha, hb;
    @(negedge clk);
    rst = r; in_valid = v; in_bit = b; overlap = ov; clr_cnt = clr;
    ha = 1'b0;
    hb = 1'b0;
    if (r) begin
      qa.delete(); qb.delete(); ca = 0; cb = 0;
    end else begin
      if (v) begin
        qa.push_back(b);
        if (qa.size() > PW_A) void'(qa.pop_front());
        ha = window_matches(qa, PW_A, PAT_A);
        if (ha && !ov) qa.delete();
        qb.push_back(b);
        if (qb.size() > PW_B) void'(qb.pop_front());
        hb = window_matches(qb, PW_B, PAT_B);
        if (hb && !ov) qb.delete();
      end
      if (clr) begin ca = 0; cb = 0; end
      else begin
        if (ha) ca++;
        if (hb) cb++;
      end
    end
    if (ha) hits_a++;
    if (hb) hits_b++;
    expa.push_back(make_exp(ha, ca, MAX_A));
    expb.push_back(make_exp(hb, cb, MAX_B));
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input bit ov);
    for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b1, bits[i], ov, 1'b0);
  endtask

  // Monitor: score every registered output cycle against the predicted response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expa.size() > 0) begin
        e = expa.pop_front();
        chk("a_out", {31'b0, out_a}, {31'b0, e.out});
        chk("a_cnt", {24'b0, cnt_a}, e.cnt);
        chk("a_sat", {31'b0, sat_a}, {31'b0, e.sat});
      end
      if (expb.size() > 0) begin
        e = expb.pop_front();
        chk("b_out", {31'b0, out_b}, {31'b0, e.out});
        chk("b_cnt", {30'b0, cnt_b}, e.cnt);
        chk("b_sat", {31'b0, sat_b}, {31'b0, e.sat});
      end
    end
  end

  initial begin
    // Reset state.
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    // 0101010100 overlapping, then non-overlapping.
    send_bits(32'b0101010100, 10, 1'b1);
    drive(1, 0, 0, 1, 0);
    send_bits(32'b0101010100, 10, 1'b0);
    // 101, five idle cycles, then 0.
    drive(1, 0, 0, 1, 0);
    send_bits(32'b101, 3, 1'b1);
    for (int i = 0; i < 5; i++) drive(0, 0, i[0], 1, 0);
    send_bits(32'b0, 1, 1'b1);
    // Reset discards a partial match.
    send_bits(32'b101, 3, 1'b1);
    drive(1, 1, 0, 1, 0);
    send_bits(32'b0, 1, 1'b1);
    send_bits(32'b1010, 4, 1'b1);
    // Runs of ones: back-to-back strobes on B with overlap, every third bit without.
    drive(1, 0, 0, 1, 0);
    send_bits(32'b111111, 6, 1'b1);
    drive(1, 0, 0, 0, 0);
    send_bits(32'b111111, 6, 1'b0);
    // Saturate B, then clear on a hit cycle.
    drive(1, 0, 0, 1, 0);
    send_bits(32'b1111111, 7, 1'b1);
    drive(0, 1, 1, 1, 1);
    send_bits(32'b11, 2, 1'b1);
    // Randomized traffic with overlap changes, clears and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(199) == 0), ($urandom_range(9) < 8), $urandom_range(1),
            (i % 64 < 32) ? 1'b1 : ($urandom_range(1) == 1), ($urandom_range(49) == 0));
    end
    // Long 1010 run to saturate A's counter, then clear.
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 300; i++) send_bits(32'b1010, 4, 1'b1);
    drive(0, 1, 1, 1, 1);
    send_bits(32'b010, 3, 1'b1);
    drive(0, 0, 0, 1, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", expa.size() + expb.size(), 0);
    chk("hits_seen_a", {31'b0, (hits_a > 300)}, 32'd1);
    chk("hits_seen_b", {31'b0, (hits_b > 100)}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
